lcd_rgb_timing_gen: RTL and testbench
=====================================

// Module: lcd_rgb_timing_gen
// PURPOSE
// Parallel-RGB LCD timing generator in the LCD pixel-clock domain, downstream of the LCD PLL.
// - Produces HSYNC/VSYNC/DE and pixel coordinates.
// - Fetches RGB565 pixels from the upstream frame/line buffer with a 1-cycle-ahead data_req.
// - Expands RGB565 to RGB888 and drives the panel pins with all signals mutually aligned.
// PARAMETERS
// H_ACTIVE  480  visible pixels per line
// H_FP      8    horizontal front porch (clocks)
// H_SYNC    4    HSYNC width (clocks)
// H_BP      43   horizontal back porch (clocks)
// V_ACTIVE  272  visible lines per frame
// V_FP      8    vertical front porch (lines)
// V_SYNC    4    VSYNC width (lines)
// V_BP      12   vertical back porch (lines)
// HS_POL    0    HSYNC active level (0 = active-low)
// VS_POL    0    VSYNC active level (0 = active-low)
// CNT_W     11   width of the h/v counters and of pix_x/pix_y
// PORTS
// clk          in   1      LCD pixel clock (PLL output, via global buffer)
// reset        in   1      synchronous, active-high
// en           in   1      run request; sampled only at frame boundaries
// frame_start  out  1      1-cycle pulse, aligned with data_req, for position (0,0)
// data_req     out  1      request rgb_in for pixel (pix_x,pix_y) in the next cycle
// pix_x        out  CNT_W  active column of the requested pixel (0 when data_req=0)
// pix_y        out  CNT_W  active row of the requested pixel (0 when data_req=0)
// rgb_in       in   16     RGB565 pixel; must be valid exactly 1 cycle after data_req
// lcd_hs       out  1      HSYNC
// lcd_vs       out  1      VSYNC
// lcd_de       out  1      data enable
// lcd_rgb      out  24     {R8,G8,B8}; 0 whenever lcd_de=0
// BEHAVIOUR
// - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP. V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
// - Region order per line and per frame: SYNC, BP, ACTIVE, FP.
// - FSM: IDLE, RUN.
//   - IDLE: h=v=0; no data_req or frame_start; lcd_* at idle values.
//   - IDLE -> RUN when en=1. The first RUN cycle is position (0,0).
//   - RUN: h increments every clock. At h=H_TOTAL-1, h wraps to 0 and v increments.
//   - At h=H_TOTAL-1 and v=V_TOTAL-1: with en=1, wrap to (0,0) and stay in RUN; with en=0, go to IDLE.
//   - en low mid-frame always completes the current frame. No partial frames.
// - Stage 1 (registered from the counters):
//   - data_req=1 iff h is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
//   - pix_x = h-(H_SYNC+H_BP). pix_y = v-(V_SYNC+V_BP).
//   - frame_start = 1 for (h,v)=(0,0) in RUN.
//   - Internal hs_a = (h<H_SYNC). Internal vs_a = (v<V_SYNC), covering whole lines.
// - Stage 2: rgb_in is registered together with the stage-1 hs_a/vs_a/de, delayed by one cycle.
//   - Result: lcd_de, lcd_hs, lcd_vs and lcd_rgb for a pixel appear exactly 2 cycles after its data_req.
// - RGB565 to RGB888 expansion: R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}.
// - Pin levels: lcd_hs = hs_a ? HS_POL : ~HS_POL; lcd_vs likewise with VS_POL.
// - Reset, including mid-frame: on the next edge go to IDLE with h=v=0 and the pipeline flushed.
//   - data_req, frame_start, pix_x, pix_y, lcd_de, lcd_rgb = 0.
//   - lcd_hs = ~HS_POL, lcd_vs = ~VS_POL.
// - en=1 held through reset: RUN starts on the first clock after reset deasserts.
// - Per line: exactly H_ACTIVE data_req cycles. Per frame: exactly H_ACTIVE*V_ACTIVE data_req cycles.
// - All outputs are registered. No combinational path from any input to any output.
// TESTING
// T1: Defaults, en=1.
//   - Required: 535 clocks between HS edges, of which 4 are active-low.
//   - Required: 158360 clocks between frame_start pulses; 480 DE cycles per line; 272 DE lines per frame.
// T2: Small params H 4/1/1/2, V 3/1/1/1 (H_TOTAL=8, V_TOTAL=6).
//   - Required: frame_start every 48 clocks.
//   - Required: data_req with pix_x 0..3 at h=3..6 of lines v=2..4.
//   - Required: lcd_de exactly 2 cycles after data_req.
// T3: rgb_in=16'hF800 -> lcd_rgb=24'hFF0000. 16'h0841 -> 24'h080808. 16'hFFFF -> 24'hFFFFFF.
//   - Required: lcd_rgb=0 during blanking.
// T4: T2 params, drop en at clock 20 of a frame.
//   - Required: the frame completes (12 data_req total), then IDLE with no frame_start.
//   - Then raise en: first frame_start pulse 2 clocks later, and the next frame starts at (0,0).
// T5: Assert reset for 1 clock mid-active-line.
//   - Required: on the next cycle lcd_de=0, lcd_rgb=0, lcd_hs=lcd_vs=1, data_req=0.
//   - Required: with en=1 held, a clean frame_start follows.
// T6: T2 params with HS_POL=1, VS_POL=1.
//   - Required: HS and VS are high only during their sync regions; VS spans exactly 8 clocks.

Source files
------------

// File: rtl/lcd_rgb_timing_gen.sv
// -----------------------------------------------------------------------------
// lcd_rgb_timing_gen
//
// Parallel-RGB LCD timing generator running in the LCD pixel-clock domain.
// A horizontal/vertical position counter drives a two-state run/idle FSM and a
// small output pipeline:
//   stage 1 : data_req / pix_x / pix_y / frame_start and the internal sync
//             levels, all registered from the counters.
//   delay   : sync levels and DE held one cycle while the upstream buffer
//             answers the request.
//   stage 2 : rgb_in captured together with the delayed sync/DE, expanded
//             from RGB565 to RGB888 and driven to the panel pins.
// A pixel requested on data_req therefore reaches lcd_de/lcd_hs/lcd_vs/lcd_rgb
// exactly two cycles later, with every pin mutually aligned.
//
// Request protocol: data_req is a fixed-latency request, not a valid/ready
// handshake. When data_req is high in cycle N for pixel (pix_x,pix_y), the
// source must present that pixel on rgb_in throughout cycle N+1; there is no
// back-pressure and rgb_in is ignored whenever no request is outstanding.
//
// Ports
//   clk          in   LCD pixel clock
//   reset        in   synchronous, active-high
//   en           in   run request, acted on only at frame boundaries
//   frame_start  out  1-cycle pulse for position (0,0), aligned with data_req
//   data_req     out  request rgb_in for (pix_x,pix_y) in the next cycle
//   pix_x/pix_y  out  active column/row of the requested pixel (0 otherwise)
//   rgb_in       in   RGB565 pixel, valid one cycle after data_req
//   lcd_hs/vs    out  HSYNC / VSYNC pins (polarity from HS_POL / VS_POL)
//   lcd_de       out  data enable pin
//   lcd_rgb      out  {R8,G8,B8}, forced to 0 while lcd_de is low
//   dbg_run      out  FSM state (1 = RUN, 0 = IDLE)
// -----------------------------------------------------------------------------
module lcd_rgb_timing_gen #(
  parameter int   H_ACTIVE = 480,
  parameter int   H_FP     = 8,
  parameter int   H_SYNC   = 4,
  parameter int   H_BP     = 43,
  parameter int   V_ACTIVE = 272,
  parameter int   V_FP     = 8,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 12,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CNT_W    = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             frame_start,
  output logic             data_req,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  input  logic [15:0]      rgb_in,
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic             lcd_de,
  output logic [23:0]      lcd_rgb,
  output logic             dbg_run
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_E  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_E  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_B   = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_E   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_B   = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_E   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;

  // stage 1
  logic             data_req_q, data_req_d;
  logic             frame_start_q, frame_start_d;
  logic [CNT_W-1:0] pix_x_q, pix_x_d;
  logic [CNT_W-1:0] pix_y_q, pix_y_d;
  logic             hs_a_q, hs_a_d;
  logic             vs_a_q, vs_a_d;

  // delay stage (waits for the upstream buffer to answer)
  logic             de_p_q, de_p_d;
  logic             hs_p_q, hs_p_d;
  logic             vs_p_q, vs_p_d;

  // stage 2 (pins)
  logic             lcd_de_q, lcd_de_d;
  logic             lcd_hs_q, lcd_hs_d;
  logic             lcd_vs_q, lcd_vs_d;
  logic [23:0]      lcd_rgb_q, lcd_rgb_d;

  logic             run;
  logic             h_in_act;
  logic             v_in_act;
  logic [4:0]       r5;
  logic [5:0]       g6;
  logic [4:0]       b5;

  // ---------------------------------------------------------------------------
  // FSM and position counters
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    unique case (state_q)
      ST_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            // en only matters here, so a frame is never cut short
            v_d = '0;
            if (!en) state_d = ST_IDLE;
          end else begin
            v_d = v_q + CNT_ONE;
          end
        end else begin
          h_d = h_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        h_d     = '0;
        v_d     = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    run      = (state_q == ST_RUN);
    h_in_act = (h_q >= H_ACT_B) && (h_q < H_ACT_E);
    v_in_act = (v_q >= V_ACT_B) && (v_q < V_ACT_E);

    data_req_d    = run && h_in_act && v_in_act;
    frame_start_d = run && (h_q == '0) && (v_q == '0);
    pix_x_d       = data_req_d ? (h_q - H_ACT_B) : '0;
    pix_y_d       = data_req_d ? (v_q - V_ACT_B) : '0;
    hs_a_d        = run && (h_q < H_SYNC_E);
    vs_a_d        = run && (v_q < V_SYNC_E);

    de_p_d = data_req_q;
    hs_p_d = hs_a_q;
    vs_p_d = vs_a_q;

    // replicate the top bits into the new LSBs so full-scale stays full-scale
    r5 = rgb_in[15:11];
    g6 = rgb_in[10:5];
    b5 = rgb_in[4:0];

    lcd_de_d  = de_p_q;
    lcd_hs_d  = hs_p_q ? HS_POL : ~HS_POL;
    lcd_vs_d  = vs_p_q ? VS_POL : ~VS_POL;
    lcd_rgb_d = de_p_q ? {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]} : 24'h0;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      h_q           <= '0;
      v_q           <= '0;
      data_req_q    <= 1'b0;
      frame_start_q <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      hs_a_q        <= 1'b0;
      vs_a_q        <= 1'b0;
      de_p_q        <= 1'b0;
      hs_p_q        <= 1'b0;
      vs_p_q        <= 1'b0;
      lcd_de_q      <= 1'b0;
      lcd_hs_q      <= ~HS_POL;
      lcd_vs_q      <= ~VS_POL;
      lcd_rgb_q     <= 24'h0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      data_req_q    <= data_req_d;
      frame_start_q <= frame_start_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      hs_a_q        <= hs_a_d;
      vs_a_q        <= vs_a_d;
      de_p_q        <= de_p_d;
      hs_p_q        <= hs_p_d;
      vs_p_q        <= vs_p_d;
      lcd_de_q      <= lcd_de_d;
      lcd_hs_q      <= lcd_hs_d;
      lcd_vs_q      <= lcd_vs_d;
      lcd_rgb_q     <= lcd_rgb_d;
    end
  end

  assign frame_start = frame_start_q;
  assign data_req    = data_req_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign lcd_hs      = lcd_hs_q;
  assign lcd_vs      = lcd_vs_q;
  assign lcd_de      = lcd_de_q;
  assign lcd_rgb     = lcd_rgb_q;
  assign dbg_run     = (state_q == ST_RUN);

endmodule

// File: tb/tb_lcd_rgb_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_lcd_rgb_timing_gen
//
// Three instances share one clock:
//   u_a : default 480x272 timing (line-level checks only)
//   u_b : small timing H 4/1/1/2, V 3/1/1/1 (8 x 6 positions per frame)
//   u_c : same small timing with active-high HSYNC/VSYNC
// The bench plays the upstream buffer: one cycle after it sees data_req it
// drives rgb_in with a palette entry picked by pix_x, and drives 16'hFFFF
// otherwise so blanking must still show lcd_rgb = 0.
// -----------------------------------------------------------------------------
module tb_lcd_rgb_timing_gen;

  localparam int CW = 11;

  logic          clk;
  int            checks = 0;
  int            errors = 0;

  logic          rst_a, en_a, fs_a, dr_a, hs_a, vs_a, de_a, dbg_a;
  logic [CW-1:0] px_a, py_a;
  logic [15:0]   rgb_a;
  logic [23:0]   out_a;

  logic          rst_b, en_b, fs_b, dr_b, hs_b, vs_b, de_b, dbg_b;
  logic [CW-1:0] px_b, py_b;
  logic [15:0]   rgb_b;
  logic [23:0]   out_b;

  logic          rst_c, en_c, fs_c, dr_c, hs_c, vs_c, de_c, dbg_c;
  logic [CW-1:0] px_c, py_c;
  logic [15:0]   rgb_c;
  logic [23:0]   out_c;

  lcd_rgb_timing_gen u_a (
    .clk(clk), .reset(rst_a), .en(en_a), .frame_start(fs_a), .data_req(dr_a),
    .pix_x(px_a), .pix_y(py_a), .rgb_in(rgb_a), .lcd_hs(hs_a), .lcd_vs(vs_a),
    .lcd_de(de_a), .lcd_rgb(out_a), .dbg_run(dbg_a)
  );

  lcd_rgb_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_b (
    .clk(clk), .reset(rst_b), .en(en_b), .frame_start(fs_b), .data_req(dr_b),
    .pix_x(px_b), .pix_y(py_b), .rgb_in(rgb_b), .lcd_hs(hs_b), .lcd_vs(vs_b),
    .lcd_de(de_b), .lcd_rgb(out_b), .dbg_run(dbg_b)
  );

  lcd_rgb_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_c (
    .clk(clk), .reset(rst_c), .en(en_c), .frame_start(fs_c), .data_req(dr_c),
    .pix_x(px_c), .pix_y(py_c), .rgb_in(rgb_c), .lcd_hs(hs_c), .lcd_vs(vs_c),
    .lcd_de(de_c), .lcd_rgb(out_c), .dbg_run(dbg_c)
  );

  // ---------------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] pal(input logic [1:0] i);
    case (i)
      2'd0:    pal = 16'hF800;
      2'd1:    pal = 16'h0841;
      2'd2:    pal = 16'hFFFF;
      default: pal = 16'h07E0;
    endcase
  endfunction

  // hand-expanded RGB888 for each palette entry
  function automatic logic [23:0] exp888(input logic [1:0] i);
    case (i)
      2'd0:    exp888 = 24'hFF0000;
      2'd1:    exp888 = 24'h080808;
      2'd2:    exp888 = 24'hFFFFFF;
      default: exp888 = 24'h00FF00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled on the falling edge. Upstream answers a
  // request seen in the previous sample.
  task automatic tick();
    logic       db, dc;
    logic [1:0] xb, xc;
    db = dr_b; xb = px_b[1:0];
    dc = dr_c; xc = px_c[1:0];
    @(posedge clk);
    @(negedge clk);
    rgb_b = db ? pal(xb) : 16'hFFFF;
    rgb_c = dc ? pal(xc) : 16'hFFFF;
  endtask

  // expected stage-1 values per sample for the u_b frame run
  logic e_dr[0:139];
  logic e_fs[0:139];
  logic e_hs[0:139];
  logic e_vs[0:139];
  int   e_px[0:139];
  int   e_py[0:139];

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int pos, h, v, n_dr, n_dr2, n_fs, cnt_hs, cnt_vs;
    int last_fall, line_de, line_dr, low_run, n_de_lines, n_fs_a, n_vs_low;
    logic running, prev_hs;

    rst_a = 1'b1; en_a = 1'b0; rgb_a = 16'h0841;
    rst_b = 1'b1; en_b = 1'b0; rgb_b = 16'hFFFF;
    rst_c = 1'b1; en_c = 1'b0; rgb_c = 16'hFFFF;
    @(negedge clk);
    tick(); tick(); tick();

    // ---- reset state ----
    chk("rst_b data_req", 32'(dr_b), 0);
    chk("rst_b frame_start", 32'(fs_b), 0);
    chk("rst_b pix_x", 32'(px_b), 0);
    chk("rst_b pix_y", 32'(py_b), 0);
    chk("rst_b lcd_de", 32'(de_b), 0);
    chk("rst_b lcd_rgb", 32'(out_b), 0);
    chk("rst_b lcd_hs", 32'(hs_b), 1);
    chk("rst_b lcd_vs", 32'(vs_b), 1);
    chk("rst_b state", 32'(dbg_b), 0);
    chk("rst_c lcd_hs", 32'(hs_c), 0);
    chk("rst_c lcd_vs", 32'(vs_c), 0);
    chk("rst_c outs", 32'({fs_c, dr_c, de_c, dbg_c}), 0);
    chk("rst_c pix", 32'({px_c, py_c}), 0);
    chk("rst_c lcd_rgb", 32'(out_c), 0);
    chk("rst_a outs", 32'({fs_a, dr_a, de_a, dbg_a, hs_a, vs_a}), 32'h3);
    chk("rst_a pix", 32'({px_a, py_a}), 0);
    chk("rst_a lcd_rgb", 32'(out_a), 0);

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick();
    chk("idle_b state", 32'(dbg_b), 0);
    chk("idle_b frame_start", 32'(fs_b), 0);

    // ---- small timing: two frames, en dropped mid second frame ----
    en_b = 1'b1;
    tick();
    chk("b start state", 32'(dbg_b), 1);
    chk("b start frame_start", 32'(fs_b), 0);
    e_dr[0] = 1'b0; e_fs[0] = 1'b0; e_hs[0] = 1'b0; e_vs[0] = 1'b0;
    e_px[0] = 0;    e_py[0] = 0;
    n_dr = 0; n_dr2 = 0; n_fs = 0;
    for (int s = 1; s <= 130; s++) begin
      if (s == 69) en_b = 1'b0;
      tick();
      pos     = s - 1;
      running = (pos < 96);
      h       = pos % 8;
      v       = (pos / 8) % 6;
      e_dr[s] = running && (h >= 3) && (h <= 6) && (v >= 2) && (v <= 4);
      e_px[s] = e_dr[s] ? h - 3 : 0;
      e_py[s] = e_dr[s] ? v - 2 : 0;
      e_fs[s] = running && (pos % 48 == 0);
      e_hs[s] = running && (h == 0);
      e_vs[s] = running && (v == 0);
      chk("b data_req", 32'(dr_b), 32'(e_dr[s]));
      chk("b pix_x", 32'(px_b), 32'(e_px[s]));
      chk("b pix_y", 32'(py_b), 32'(e_py[s]));
      chk("b frame_start", 32'(fs_b), 32'(e_fs[s]));
      if (s >= 2) begin
        chk("b lcd_de", 32'(de_b), 32'(e_dr[s-2]));
        chk("b lcd_hs", 32'(hs_b), e_hs[s-2] ? 0 : 1);
        chk("b lcd_vs", 32'(vs_b), e_vs[s-2] ? 0 : 1);
        chk("b lcd_rgb", 32'(out_b), e_dr[s-2] ? 32'(exp888(2'(e_px[s-2]))) : 0);
      end
      if (dr_b) begin
        n_dr++;
        if (s >= 49) n_dr2++;
      end
      if (fs_b) n_fs++;
    end
    chk("b data_req total", n_dr, 24);
    chk("b data_req last frame", n_dr2, 12);
    chk("b frame_start total", n_fs, 2);
    chk("b idle after frame", 32'(dbg_b), 0);

    // ---- restart: frame_start two clocks after en rises ----
    en_b = 1'b1;
    tick();
    chk("b restart fs+1", 32'(fs_b), 0);
    tick();
    chk("b restart fs+2", 32'(fs_b), 1);
    chk("b restart dr", 32'(dr_b), 0);
    for (int i = 0; i < 19; i++) tick();
    chk("b restart first dr", 32'(dr_b), 1);
    chk("b restart first px", 32'(px_b), 0);
    chk("b restart first py", 32'(py_b), 0);
    tick(); tick();
    chk("b pre-reset de", 32'(de_b), 1);
    chk("b pre-reset rgb F800", 32'(out_b), 32'h00FF0000);
    tick();
    chk("b pre-reset rgb 0841", 32'(out_b), 32'h00080808);

    // ---- one-clock reset in the middle of an active line ----
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    chk("b mid-reset de", 32'(de_b), 0);
    chk("b mid-reset rgb", 32'(out_b), 0);
    chk("b mid-reset hs", 32'(hs_b), 1);
    chk("b mid-reset vs", 32'(vs_b), 1);
    chk("b mid-reset dr", 32'(dr_b), 0);
    chk("b mid-reset fs", 32'(fs_b), 0);
    chk("b mid-reset state", 32'(dbg_b), 0);
    tick();
    chk("b post-reset fs+1", 32'(fs_b), 0);
    tick();
    chk("b post-reset fs+2", 32'(fs_b), 1);
    for (int i = 0; i < 19; i++) tick();
    chk("b post-reset dr", 32'(dr_b), 1);
    chk("b post-reset px", 32'(px_b), 0);
    tick();
    chk("b post-reset de early", 32'(de_b), 0);
    tick();
    chk("b post-reset de", 32'(de_b), 1);
    chk("b post-reset rgb", 32'(out_b), 32'h00FF0000);
    en_b = 1'b0;

    // ---- active-high sync polarity ----
    en_c = 1'b1;
    tick();
    cnt_hs = 0; cnt_vs = 0;
    for (int s = 1; s <= 52; s++) begin
      tick();
      if (s == 2)  chk("c idle hs/vs", 32'({hs_c, vs_c}), 0);
      if (s == 3)  chk("c pos0 hs/vs", 32'({hs_c, vs_c}), 32'h3);
      if (s == 4)  chk("c pos1 hs/vs", 32'({hs_c, vs_c}), 32'h1);
      if (s == 10) chk("c pos7 hs/vs", 32'({hs_c, vs_c}), 32'h1);
      if (s == 11) chk("c pos8 hs/vs", 32'({hs_c, vs_c}), 32'h2);
      if (s == 12) chk("c pos9 hs/vs", 32'({hs_c, vs_c}), 0);
      if (s >= 3 && s <= 50) begin
        if (hs_c) cnt_hs++;
        if (vs_c) cnt_vs++;
      end
    end
    chk("c vs high clocks", cnt_vs, 8);
    chk("c hs high clocks", cnt_hs, 6);
    en_c = 1'b0;

    // ---- default 480x272 timing, first 19 lines ----
    en_a = 1'b1;
    tick();
    prev_hs = 1'b1; last_fall = -1; line_de = 0; line_dr = 0; low_run = 0;
    n_de_lines = 0; n_fs_a = 0; n_vs_low = 0;
    for (int s = 1; s <= 19 * 535 + 10; s++) begin
      tick();
      if (s == 1) chk("a first frame_start", 32'(fs_a), 1);
      if (fs_a) n_fs_a++;
      if (prev_hs && !hs_a) begin
        if (last_fall >= 0) chk("a hs period", s - last_fall, 535);
        if (last_fall >= 0 && line_de != 0) begin
          chk("a de per line", line_de, 480);
          chk("a data_req per line", line_dr, 480);
          n_de_lines++;
        end
        line_de = 0; line_dr = 0;
        last_fall = s;
      end
      if (!prev_hs && hs_a) begin
        chk("a hs low width", low_run, 4);
        low_run = 0;
      end
      if (!hs_a) low_run++;
      if (!vs_a) n_vs_low++;
      if (de_a) line_de++;
      if (dr_a) line_dr++;
      if (s == 8607) chk("a dr before active", 32'(dr_a), 0);
      if (s == 8608) begin
        chk("a first dr", 32'(dr_a), 1);
        chk("a first px/py", 32'({px_a, py_a}), 0);
      end
      if (s == 8609) chk("a de lag", 32'(de_a), 0);
      if (s == 8610) begin
        chk("a first de", 32'(de_a), 1);
        chk("a first rgb", 32'(out_a), 32'h00080808);
      end
      prev_hs = hs_a;
    end
    chk("a de lines seen", n_de_lines, 3);
    chk("a frame_start count", n_fs_a, 1);
    chk("a vs low clocks", n_vs_low, 2140);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
